// File: rtl/instr_issue_unit_if.sv
// Fetch/issue bus between the issue unit, its instruction ROM,
// the branch-resolution logic and the control-unit decoder.
interface instr_issue_unit_if #(
  parameter int PC_W = 8,
  parameter int IW   = 16
);
  logic [PC_W-1:0] imem_addr;
  logic [IW-1:0]   imem_rdata;
  logic            hold_in;
  logic            redirect_valid;
  logic [PC_W-1:0] redirect_pc;
  logic [3:0]      Opcode;
  logic [3:0]      FunctCode;
  logic [IW-1:0]   instr_out;
  logic            issue_valid;
  logic [PC_W-1:0] issue_pc;
  logic            halted;

  modport master (
    output imem_addr,
    input  imem_rdata,
    input  hold_in,
    input  redirect_valid,
    input  redirect_pc,
    output Opcode,
    output FunctCode,
    output instr_out,
    output issue_valid,
    output issue_pc,
    output halted
  );

  modport slave (
    input  imem_addr,
    output imem_rdata,
    output hold_in,
    output redirect_valid,
    output redirect_pc,
    input  Opcode,
    input  FunctCode,
    input  instr_out,
    input  issue_valid,
    input  issue_pc,
    input  halted
  );
endinterface

// File: rtl/instr_issue_unit.sv
// Fetch/issue sequencer: one instruction per cycle from an async-read ROM,
// with program stalls, halt, branch/jump redirect and downstream hold.
module instr_issue_unit #(
  parameter int PC_W = 8,
  parameter int IW   = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  instr_issue_unit_if.master  io_bus
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_PAUSE = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  localparam logic [3:0] OP_STALL = 4'b0111;
  localparam logic [3:0] OP_HALT  = 4'b1111;

  state_t          r_state;
  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] r_issue_pc;
  logic [IW-1:0]   r_ir;
  logic            r_issue_valid;
  logic            r_halted;
  logic [3:0]      r_pause_cnt;

  logic [3:0]      w_fetch_op;
  logic [3:0]      w_fetch_n;

  assign w_fetch_op = io_bus.imem_rdata[IW-1:IW-4];
  assign w_fetch_n  = io_bus.imem_rdata[3:0];

  // Sequencer: priority is halt > redirect > hold > normal fetch/pause.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_RUN;
      r_pc          <= '0;
      r_issue_pc    <= '0;
      r_ir          <= '0;
      r_issue_valid <= 1'b0;
      r_halted      <= 1'b0;
      r_pause_cnt   <= 4'd0;
    end else begin
      case (r_state)
        ST_HALT: begin
          r_issue_valid <= 1'b0;
        end
        ST_RUN, ST_PAUSE: begin
          if (io_bus.redirect_valid) begin
            // Whatever the ROM shows this cycle belongs to the wrong path.
            r_pc          <= io_bus.redirect_pc;
            r_ir          <= '0;
            r_issue_valid <= 1'b0;
            r_pause_cnt   <= 4'd0;
            r_state       <= ST_RUN;
          end else if (io_bus.hold_in) begin
            r_state <= r_state;
          end else if (r_state == ST_RUN) begin
            r_ir          <= io_bus.imem_rdata;
            r_issue_pc    <= r_pc;
            r_issue_valid <= 1'b1;
            r_pc          <= r_pc + {{(PC_W-1){1'b0}}, 1'b1};
            if (w_fetch_op == OP_HALT) begin
              r_state  <= ST_HALT;
              r_halted <= 1'b1;
            end else if ((w_fetch_op == OP_STALL) && (w_fetch_n != 4'd0)) begin
              r_state     <= ST_PAUSE;
              r_pause_cnt <= w_fetch_n;
            end else begin
              r_state <= ST_RUN;
            end
          end else begin
            r_issue_valid <= 1'b0;
            r_pause_cnt   <= r_pause_cnt - 4'd1;
            if (r_pause_cnt == 4'd1) begin
              r_state <= ST_RUN;
            end else begin
              r_state <= ST_PAUSE;
            end
          end
        end
        default: begin
          r_state       <= ST_RUN;
          r_issue_valid <= 1'b0;
        end
      endcase
    end
  end

  assign io_bus.imem_addr   = r_pc;
  assign io_bus.Opcode      = r_issue_valid ? r_ir[IW-1:IW-4] : OP_STALL;
  assign io_bus.FunctCode   = r_issue_valid ? r_ir[3:0] : 4'b0000;
  assign io_bus.instr_out   = r_issue_valid ? r_ir : {IW{1'b0}};
  assign io_bus.issue_valid = r_issue_valid;
  assign io_bus.issue_pc    = r_issue_pc;
  assign io_bus.halted      = r_halted;

endmodule

// File: tb/tb_instr_issue_unit.sv
// Scoreboard bench for instr_issue_unit: directed program walk followed by
// randomized hold/redirect traffic over a random ROM image.
module tb_instr_issue_unit;

  logic clk;
  logic rst_n;

  instr_issue_unit_if #(.PC_W(8), .IW(16)) bus ();

  instr_issue_unit #(.PC_W(8), .IW(16)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (bus)
  );

  logic [15:0] rom [0:255];
  assign bus.imem_rdata = rom[bus.imem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [15:0] instr;
    logic [7:0]  ipc;
    logic [7:0]  addr;
    logic        halt;
  } exp_t;

  exp_t q [$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model: fetch pointer, bubbles still owed, halt flag, shown issue.
  logic [7:0]  m_pc;
  int          m_bub;
  logic        m_halt;
  logic        m_valid;
  logic [15:0] m_instr;
  logic [7:0]  m_ipc;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 8'd0; m_bub = 0; m_halt = 1'b0;
    m_valid = 1'b0; m_instr = 16'd0; m_ipc = 8'd0;
  endtask

  // One clock of stimulus; expected post-edge view is queued for the monitor.
  task automatic step(input logic h, input logic rd, input logic [7:0] rpc);
    exp_t        e;
    logic [15:0] ins;
    bus.hold_in        = h;
    bus.redirect_valid = rd;
    bus.redirect_pc    = rpc;
    if (m_halt) begin
      m_valid = 1'b0;
    end else if (rd) begin
      m_pc = rpc; m_bub = 0; m_valid = 1'b0;
    end else if (h) begin
      m_bub = m_bub;
    end else if (m_bub > 0) begin
      m_bub--; m_valid = 1'b0;
    end else begin
      ins = rom[m_pc];
      m_valid = 1'b1; m_instr = ins; m_ipc = m_pc;
      m_pc = m_pc + 8'd1;
      if (ins[15:12] == 4'hF) m_halt = 1'b1;
      else if (ins[15:12] == 4'h7) m_bub = int'(ins[3:0]);
    end
    e.valid = m_valid; e.instr = m_instr; e.ipc = m_ipc;
    e.addr = m_pc; e.halt = m_halt;
    q.push_back(e);
    @(posedge clk);
    #2;
    bus.hold_in        = 1'b0;
    bus.redirect_valid = 1'b0;
  endtask

  task automatic chk_reset_view(input string tag);
    chk({tag, "_valid"},  32'(bus.issue_valid), 32'd0);
    chk({tag, "_opcode"}, 32'(bus.Opcode),      32'h7);
    chk({tag, "_funct"},  32'(bus.FunctCode),   32'h0);
    chk({tag, "_instr"},  32'(bus.instr_out),   32'h0);
    chk({tag, "_ipc"},    32'(bus.issue_pc),    32'h0);
    chk({tag, "_addr"},   32'(bus.imem_addr),   32'h0);
    chk({tag, "_halted"}, 32'(bus.halted),      32'h0);
  endtask

  // Asynchronous reset dropped between clock edges.
  task automatic do_reset();
    #1;
    rst_n = 1'b0;
    #1;
    chk_reset_view("async_rst");
    model_reset();
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: compares the DUT view just after every edge against the queue.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("issue_valid", 32'(bus.issue_valid), 32'(e.valid));
        chk("opcode",      32'(bus.Opcode),      e.valid ? 32'(e.instr[15:12]) : 32'h7);
        chk("funct",       32'(bus.FunctCode),   e.valid ? 32'(e.instr[3:0]) : 32'h0);
        chk("instr_out",   32'(bus.instr_out),   e.valid ? 32'(e.instr) : 32'h0);
        chk("issue_pc",    32'(bus.issue_pc),    32'(e.ipc));
        chk("imem_addr",   32'(bus.imem_addr),   32'(e.addr));
        chk("halted",      32'(bus.halted),      32'(e.halt));
      end
    end
  end

  initial begin
    int r;
    rst_n = 1'b0;
    bus.hold_in = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 8'd0;
    for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
    rom[0] = 16'h0120; rom[1] = 16'h0341; rom[2] = 16'h0562;
    rom[3] = 16'h7003; rom[4] = 16'h0784; rom[5] = 16'h6A05;
    rom[8'h20] = 16'h3456; rom[8'h21] = 16'h7000; rom[8'h22] = 16'h7005;
    for (int i = 0; i < 8; i++) rom[8'h30 + i] = 16'h1110 + 16'(i);
    rom[8'h40] = 16'h0AAA; rom[8'h41] = 16'hF000;
    model_reset();
    #3;
    chk_reset_view("in_reset");
    #4;
    rst_n = 1'b1;
    #1;
    chk_reset_view("pre_edge");

    // Sequential fetch, a 3-cycle stall, then a redirect while issue_pc=5.
    repeat (9) step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'h20);
    // Zero-length stall, then a 5-cycle stall cancelled by a redirect.
    repeat (5) step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'h30);
    repeat (9) step(1'b0, 1'b0, 8'h00);
    // Four hold cycles, then redirect and hold together.
    repeat (4) step(1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b1, 8'h40);
    step(1'b1, 1'b0, 8'h00);
    repeat (4) step(1'b0, 1'b0, 8'h00);
    // Halted: hold/redirect must be ignored.
    for (int i = 0; i < 10; i++) step(1'(i % 2), 1'(i % 3 == 0), 8'h05);
    chk("halted_sticky", 32'(bus.halted), 32'd1);
    do_reset();

    // PC wrap from 0xFF to 0x00.
    rom[8'hFF] = 16'h0ABC;
    step(1'b0, 1'b1, 8'hFF);
    repeat (3) step(1'b0, 1'b0, 8'h00);

    // Async reset in the middle of a long pause.
    rom[8'h10] = 16'h7009;
    step(1'b0, 1'b1, 8'h10);
    repeat (4) step(1'b0, 1'b0, 8'h00);
    do_reset();
    chk("first_fetch_addr", 32'(bus.imem_addr), 32'h0);

    // Randomized program image and control traffic.
    for (int i = 0; i < 256; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 2) rom[i] = 16'hF000;
      else if (r < 14) rom[i] = {4'h7, 8'($urandom), 4'($urandom_range(0, 4))};
      else begin
        rom[i] = 16'($urandom);
        if (rom[i][15:12] == 4'h7 || rom[i][15:12] == 4'hF) rom[i][15:12] = 4'h2;
      end
    end
    for (int i = 0; i < 500; i++) begin
      step(1'($urandom_range(0, 9) < 2), 1'($urandom_range(0, 9) == 0), 8'($urandom));
      if (m_halt && ($urandom_range(0, 7) == 0)) do_reset();
    end

    @(posedge clk);
    #3;
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/instr_issue_unit.md
Name: instr_issue_unit

Overview:
Front-end fetch/issue sequencer. It produces the Opcode/FunctCode stream that the control unit decodes, and it is the producer side of that interface. It reads 16-bit instructions from an asynchronous-read instruction ROM into an instruction register and issues one instruction per cycle. It sequences program stalls (opcode 0111), halt (opcode 1111), redirects from branch/jump resolution, and downstream hold.

Parameters:
PC_W, 8, instruction address width (word addressed; PC increments by 1)
IW, 16, instruction width; opcode = [15:12], funct/immediate = [3:0]

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset
imem_addr  out  PC_W  ROM address (= pc register)
imem_rdata  in  IW  ROM data for imem_addr, same cycle (combinational read)
hold_in  in  1  downstream hazard hold; freezes the unit
redirect_valid  in  1  branch taken or jump, resolved for the currently issued instruction
redirect_pc  in  PC_W  target address
Opcode  out  4  to control unit; ir[15:12] when issue_valid, else 4'b0111 (bubble)
FunctCode  out  4  ir[3:0] when issue_valid, else 4'b0000
instr_out  out  IW  full IR for operand fields; 0 when not valid
issue_valid  out  1  Opcode/FunctCode carry a real instruction
issue_pc  out  PC_W  address of the issued instruction
halted  out  1  halt reached; sticky until reset

Behaviour:
- Interface (already decided): one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values: pc=0, ir=0, issue_pc=0, issue_valid=0, pause_cnt=0, halted=0, state=RUN. Outputs read Opcode=0111, FunctCode=0000.
- States: RUN, PAUSE, HALT. Latency from imem_addr to Opcode is 1 cycle.
- Per-edge priority: reset > HALT state > redirect_valid > hold_in > normal.
- RUN, normal case:
  - ir<=imem_rdata, issue_pc<=pc, issue_valid<=1, pc<=pc+1.
  - pc wraps modulo 2^PC_W (max -> 0).
- RUN, captured opcode 1111: the halt instruction is issued once. state<=HALT, pc frozen at its value+1, and halted<=1 on the same edge.
- RUN, captured opcode 0111: the stall instruction is issued (issue_valid=1).
  - If imem_rdata[3:0]=N>0: state<=PAUSE, pause_cnt<=N.
  - If N=0: stay in RUN.
- PAUSE:
  - issue_valid<=0, pc frozen, pause_cnt decrements each cycle.
  - When pause_cnt=1 at the edge, state<=RUN. This gives exactly N bubble cycles, after which fetch resumes at the next sequential pc.
- hold_in=1 (RUN or PAUSE): pc, ir, issue_pc, issue_valid, pause_cnt and state all hold their values. The issued outputs stay stable for the whole hold.
- redirect_valid=1 (RUN or PAUSE, checked before hold):
  - pc<=redirect_pc, issue_valid<=0, ir<=0, state<=RUN, pause_cnt<=0.
  - Exactly one bubble follows. The next cycle issues nothing; the cycle after issues M[redirect_pc].
  - A halt or stall opcode on imem_rdata in the redirect cycle is discarded.
- HALT:
  - issue_valid<=0, all registers frozen.
  - redirect_valid and hold_in are ignored; only rst_n exits.
- redirect_valid together with hold_in: redirect wins; the hold applies from the next cycle.
- Reset asserted mid-operation (any state, including mid-PAUSE or HALT): all registers return to reset values immediately, without waiting for a clock edge. The first fetch is from address 0 on the first clk edge after deassertion.
- Outputs are combinational from registers only. No combinational path exists from any input to Opcode/FunctCode/issue_valid.

Test Plan:
- Sequential fetch: ROM[0..2]=0x0120,0x0341,0x0562, no hold/redirect.
  - Cycles 1-3 issue Opcode=0000, FunctCode=0,1,2 with issue_pc=0,1,2.
  - Before the first edge: issue_valid=0, Opcode=0111.
- Program stall: ROM[3]=0x7003.
  - Issued at issue_pc=3, followed by exactly 3 cycles with issue_valid=0.
  - Next issue is issue_pc=4.
  - Repeat with ROM[3]=0x7000: no bubble.
- Redirect: while issue_pc=5 (BEQ 0x6...), pulse redirect_valid with redirect_pc=0x20.
  - One bubble, then issue_pc=0x20 with Opcode=ROM[0x20][15:12].
  - Repeat with a redirect during PAUSE: the pause is cancelled.
- Hold: assert hold_in for 4 cycles while issue_pc=7.
  - Opcode, FunctCode, issue_pc and imem_addr=8 are stable throughout.
  - The next issue after release is issue_pc=8.
  - Redirect+hold in the same cycle: the redirect is taken.
- Halt: ROM[9]=0xF000.
  - Issued once; halted=1 from that edge; issue_valid=0 thereafter.
  - Redirect and hold are ignored for 10 cycles.
  - rst_n low clears halted=0 and pc=0 asynchronously.
- Wrap and async reset:
  - With PC_W=8, start via redirect_pc=0xFF: issues 0xFF, then 0x00.
  - Drop rst_n between clock edges mid-PAUSE: outputs reach reset values immediately.
